// File: rtl/mux_scan_pkg.sv
// rtl/mux_scan_pkg.sv - shared definitions for the mux_scan family
// Contents:
//   mode_e      : mode encodings (MODE_MANUAL=0, MODE_SCAN=1)
//   calc_width  : select/counter width for a count of n values, minimum 1 bit
package mux_pkg;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  // Width needed to index n values; a single value still gets one bit so
  // that DWELL=1 and similar degenerate cases produce legal vectors.
  function automatic int calc_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mux_scan_if.sv
// rtl/mux_scan_if.sv - channel/control/result bundle for mux_scan
// Signals:
//   in      : N*W channel data, channel k at [k*W +: W]
//   control : manual select / load target
//   mode    : 0 manual, 1 scan
//   en      : scan advance enable
//   load    : scan jump to control
//   out     : registered selected data
//   sel     : channel currently driving out
//   wrap    : one-cycle pulse on the N-1 -> 0 step
// Modports: master drives data/control, slave is the mux.
interface mux_scan_if #(
  parameter int W = 1,
  parameter int N = 4
);
  localparam int SELW = mux_pkg::calc_width(N);

  logic [N*W-1:0]  in;
  logic [SELW-1:0] control;
  logic            mode;
  logic            en;
  logic            load;
  logic [W-1:0]    out;
  logic [SELW-1:0] sel;
  logic            wrap;

  modport master (
    output in, control, mode, en, load,
    input  out, sel, wrap
  );

  modport slave (
    input  in, control, mode, en, load,
    output out, sel, wrap
  );

endinterface

// File: rtl/mux_scan_seq.sv
// rtl/mux_scan_seq.sv - channel sequencer: dwell counter, next channel, wrap
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   mode       : 0 manual, 1 scan
//   en, load   : scan advance enable, scan jump request
//   load_val   : manual select / jump target
//   sel        : channel currently registered in the top
//   sel_nxt    : channel to register at the coming edge
//   wrap_nxt   : wrap value to register at the coming edge
module scan_seq
  import mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int DWELL = 16,
  parameter int SELW  = calc_width(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mode,
  input  logic            en,
  input  logic            load,
  input  logic [SELW-1:0] load_val,
  input  logic [SELW-1:0] sel,
  output logic [SELW-1:0] sel_nxt,
  output logic            wrap_nxt
);

  localparam int CW = calc_width(DWELL);
  // Compare against N-1 rather than the all-ones code so a non-power-of-2
  // N never lets sel reach an unused channel index.
  localparam logic [SELW-1:0] SEL_LAST = SELW'(N - 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          val_ok;

  assign val_ok = (load_val <= SEL_LAST);

  always_comb begin
    sel_nxt  = sel;
    cnt_nxt  = cnt;
    wrap_nxt = 1'b0;
    if (mode == MODE_MANUAL) begin
      // Out-of-range manual selects hold the current channel.
      cnt_nxt = '0;
      if (val_ok) sel_nxt = load_val;
    end else if (load) begin
      cnt_nxt = '0;
      sel_nxt = val_ok ? load_val : '0;
    end else if (!en) begin
      // Frozen: channel and dwell position both hold.
    end else if (cnt == CNT_LAST) begin
      cnt_nxt = '0;
      if (sel == SEL_LAST) begin
        sel_nxt  = '0;
        wrap_nxt = 1'b1;
      end else begin
        sel_nxt = sel + 1'b1;
      end
    end else begin
      cnt_nxt = cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else       cnt <= cnt_nxt;
  end

endmodule

// File: rtl/mux_scan.sv
// rtl/mux_scan.sv - N-channel W-bit registered mux with manual and scan modes
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : mux_scan_if slave (in, control, mode, en, load -> out, sel, wrap)
module mux_scan
  import mux_pkg::*;
#(
  parameter int W     = 1,
  parameter int N     = 4,
  parameter int DWELL = 16
) (
  input  logic      clk,
  input  logic      reset,
  mux_scan_if.slave bus
);

  localparam int SELW = calc_width(N);

  logic [SELW-1:0] sel_nxt;
  logic            wrap_nxt;

  scan_seq #(
    .N     (N),
    .DWELL (DWELL),
    .SELW  (SELW)
  ) u_seq (
    .clk      (clk),
    .reset    (reset),
    .mode     (bus.mode),
    .en       (bus.en),
    .load     (bus.load),
    .load_val (bus.control),
    .sel      (bus.sel),
    .sel_nxt  (sel_nxt),
    .wrap_nxt (wrap_nxt)
  );

  // Data is picked with sel_nxt so out and sel always describe the same
  // channel sampled at the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out  <= '0;
      bus.sel  <= '0;
      bus.wrap <= 1'b0;
    end else begin
      bus.out  <= bus.in[int'(sel_nxt)*W +: W];
      bus.sel  <= sel_nxt;
      bus.wrap <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_mux_scan.sv
// tb/tb_mux_scan.sv - self-checking bench for mux_scan
module tb_mux_scan;

  logic clk = 1'b0;
  logic rst_a, rst_b, rst_c;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // a: legacy 4:1 single-bit, b: byte-wide DWELL=4, c: N=3 DWELL=1
  mux_scan_if #(.W(1), .N(4)) ifa ();
  mux_scan_if #(.W(8), .N(4)) ifb ();
  mux_scan_if #(.W(2), .N(3)) ifc ();

  mux_scan #(.W(1), .N(4), .DWELL(16)) u_a (.clk(clk), .reset(rst_a), .bus(ifa.slave));
  mux_scan #(.W(8), .N(4), .DWELL(4))  u_b (.clk(clk), .reset(rst_b), .bus(ifb.slave));
  mux_scan #(.W(2), .N(3), .DWELL(1))  u_c (.clk(clk), .reset(rst_c), .bus(ifc.slave));

  typedef struct {
    logic [1:0] control;
    logic [3:0] data;
    logic       exp_out;
  } vec_t;

  vec_t vecs[64];

  localparam logic [31:0] B_IN = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
  logic [7:0] b_bytes[4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  initial begin
    // Test 1 table: control steps 0..3 every 16 vectors, data walks all 16
    for (int i = 0; i < 64; i++) begin
      vecs[i].control = 2'(i / 16);
      vecs[i].data    = 4'(i % 16);
      vecs[i].exp_out = vecs[i].data[vecs[i].control];
    end

    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    ifa.in = '0; ifa.control = '0; ifa.mode = 1'b0; ifa.en = 1'b0; ifa.load = 1'b0;
    ifb.in = B_IN; ifb.control = '0; ifb.mode = 1'b1; ifb.en = 1'b1; ifb.load = 1'b0;
    ifc.in = 6'b11_10_01; ifc.control = '0; ifc.mode = 1'b1; ifc.en = 1'b1; ifc.load = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_a_out", 32'(ifa.out), 0);
    chk("rst_a_sel", 32'(ifa.sel), 0);
    chk("rst_b_out", 32'(ifb.out), 0);
    chk("rst_b_sel", 32'(ifb.sel), 0);
    chk("rst_b_wrap", 32'(ifb.wrap), 0);
    chk("rst_c_sel", 32'(ifc.sel), 0);

    // Test 1: manual 4:1 mux
    rst_a = 1'b0;
    for (int i = 0; i < 64; i++) begin
      ifa.control = vecs[i].control;
      ifa.in      = vecs[i].data;
      step();
      chk($sformatf("t1_out[%0d]", i), 32'(ifa.out), 32'(vecs[i].exp_out));
      chk($sformatf("t1_sel[%0d]", i), 32'(ifa.sel), 32'(vecs[i].control));
      chk($sformatf("t1_wrap[%0d]", i), 32'(ifa.wrap), 0);
    end

    // Test 2: scan sweep from reset, DWELL=4
    rst_b = 1'b0;
    for (int e = 1; e <= 17; e++) begin
      step();
      chk($sformatf("t2_sel[%0d]", e), 32'(ifb.sel), 32'((e / 4) % 4));
      chk($sformatf("t2_out[%0d]", e), 32'(ifb.out), 32'(b_bytes[(e / 4) % 4]));
      chk($sformatf("t2_wrap[%0d]", e), 32'(ifb.wrap), 32'(e == 16));
    end

    // Test 3: freeze at cnt=2 on channel 0, data still tracks
    step();
    chk("t3_pre_sel", 32'(ifb.sel), 0);
    ifb.en = 1'b0;
    for (int k = 0; k < 6; k++) begin
      ifb.in = {B_IN[31:8], 8'(8'h10 + k)};
      step();
      chk($sformatf("t3_frz_sel[%0d]", k), 32'(ifb.sel), 0);
      chk($sformatf("t3_frz_out[%0d]", k), 32'(ifb.out), 32'(8'h10 + k));
    end
    ifb.in = B_IN;
    ifb.en = 1'b1;
    step();
    chk("t3_resume1_sel", 32'(ifb.sel), 0);
    chk("t3_resume1_out", 32'(ifb.out), 32'h00AA);
    step();
    chk("t3_resume2_sel", 32'(ifb.sel), 1);
    chk("t3_resume2_out", 32'(ifb.out), 32'h00BB);

    // Test 4: load while sel=0, cnt=3
    ifb.load = 1'b1; ifb.control = 2'd0;
    step();
    ifb.load = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("t4_setup_sel[%0d]", k), 32'(ifb.sel), 0);
    end
    ifb.load = 1'b1; ifb.control = 2'd2;
    step();
    ifb.load = 1'b0;
    chk("t4_load_sel", 32'(ifb.sel), 2);
    chk("t4_load_wrap", 32'(ifb.wrap), 0);
    chk("t4_load_out", 32'(ifb.out), 32'h00CC);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("t4_dwell_sel[%0d]", k), 32'(ifb.sel), (k == 4) ? 3 : 2);
    end

    // Test 6: reset at sel=3, cnt=3 suppresses the wrap
    for (int k = 0; k < 3; k++) step();
    chk("t6_pre_sel", 32'(ifb.sel), 3);
    rst_b = 1'b1;
    step();
    rst_b = 1'b0;
    chk("t6_rst_out", 32'(ifb.out), 0);
    chk("t6_rst_sel", 32'(ifb.sel), 0);
    chk("t6_rst_wrap", 32'(ifb.wrap), 0);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("t6_restart_sel[%0d]", k), 32'(ifb.sel), (k == 4) ? 1 : 0);
      chk($sformatf("t6_restart_wrap[%0d]", k), 32'(ifb.wrap), 0);
    end

    // Test 5: N=3, DWELL=1 advances every cycle, wraps every third
    rst_c = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      step();
      chk($sformatf("t5_sel[%0d]", e), 32'(ifc.sel), 32'(e % 3));
      chk($sformatf("t5_out[%0d]", e), 32'(ifc.out), 32'((e % 3) + 1));
      chk($sformatf("t5_wrap[%0d]", e), 32'(ifc.wrap), 32'(e % 3 == 0));
    end
    ifc.mode = 1'b0; ifc.control = 2'd1;
    step();
    chk("t5_man_sel", 32'(ifc.sel), 1);
    ifc.control = 2'd3;
    step();
    chk("t5_hold_sel", 32'(ifc.sel), 1);
    ifc.in = 6'b11_00_01;
    step();
    chk("t5_hold_sel2", 32'(ifc.sel), 1);
    chk("t5_hold_out", 32'(ifc.out), 0);
    chk("t5_hold_wrap", 32'(ifc.wrap), 0);
    ifc.mode = 1'b1; ifc.load = 1'b1; ifc.control = 2'd3;
    step();
    chk("t5_load_oor_sel", 32'(ifc.sel), 0);
    chk("t5_load_oor_out", 32'(ifc.out), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
